reg_alu_unit: RTL and testbench



---
 rtl/reg_alu_unit.sv | 206 ++++++++++++++++++++
 tb/tb_reg_alu_unit.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_alu_unit.sv
// Register file plus sequenced ALU with start/busy/done handshake and automatic writeback.
// Optional shift-add multiplier (alu_op 8) compiled in when REG_ALU_MUL_EN is defined.
module reg_alu_unit #(
  parameter int DATA_W  = 16,
  parameter int REG_CNT = 4,
  parameter int IMM_W   = 8,
  localparam int SEL_W  = $clog2(REG_CNT)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] memval,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] sp,
  input  logic [IMM_W-1:0]  immediate,
  input  logic              wr_en,
  input  logic [SEL_W-1:0]  wr_sel,
  input  logic [1:0]        wr_src,
  input  logic [SEL_W-1:0]  rd_a_sel,
  input  logic [SEL_W-1:0]  rd_b_sel,
  output logic [DATA_W-1:0] rd_a_data,
  output logic [DATA_W-1:0] rd_b_data,
  input  logic              start,
  input  logic [3:0]        alu_op,
  input  logic              src_a,
  input  logic [1:0]        src_b,
  input  logic              wb_en,
  input  logic [SEL_W-1:0]  wb_sel,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              overflow
);

  localparam int SH_W = $clog2(DATA_W);
  localparam int MSB  = DATA_W - 1;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  typedef struct packed {
    logic             wb_en;
    logic [SEL_W-1:0] wb_sel;
  } wb_req_t;

  state_t                        state;
  wb_req_t                       wb_q;
  logic [REG_CNT-1:0][DATA_W-1:0] rf;

  logic [DATA_W-1:0] imm_zext, imm_sext, op_a, op_b, wr_data;
  logic [DATA_W:0]   alu_out;
  logic              mul_req;

  assign rd_a_data = rf[rd_a_sel];
  assign rd_b_data = rf[rd_b_sel];

  assign imm_zext = {{(DATA_W-IMM_W){1'b0}}, immediate};
  assign imm_sext = {{(DATA_W-IMM_W){immediate[IMM_W-1]}}, immediate};

  always_comb begin
    op_a = src_a ? sp : rd_a_data;
    unique case (src_b)
      2'd0:    op_b = rd_b_data;
      2'd1:    op_b = imm_zext;
      2'd2:    op_b = imm_sext;
      default: op_b = {imm_sext[DATA_W-3:0], 2'b00};
    endcase
  end

  always_comb begin
    unique case (wr_src)
      2'd0:    wr_data = memval;
      2'd1:    wr_data = result;
      2'd2:    wr_data = imm_sext;
      default: wr_data = pc;
    endcase
  end

  // Single-cycle ops; returns {overflow, result}. Op 8 falls to the reserved default.
  function automatic logic [DATA_W:0] alu_eval(input logic [3:0] op,
                                               input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    logic              v;
    r = '0;
    v = 1'b0;
    unique case (op)
      OP_ADD: begin
        r = a + b;
        v = (a[MSB] == b[MSB]) && (r[MSB] != a[MSB]);
      end
      OP_SUB: begin
        r = a - b;
        v = (a[MSB] != b[MSB]) && (r[MSB] != a[MSB]);
      end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_SLL: r = a << b[SH_W-1:0];
      OP_SRL: r = a >> b[SH_W-1:0];
      OP_SLT: r = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: ;
    endcase
    return {v, r};
  endfunction

  assign alu_out = alu_eval(alu_op, op_a, op_b);

`ifdef REG_ALU_MUL_EN
  logic [2*DATA_W-1:0] acc, mcand, acc_nxt;
  logic [DATA_W-1:0]   mplier;
  logic [SH_W-1:0]     cnt;

  assign mul_req = (alu_op == OP_MUL);
  assign acc_nxt = acc + (mplier[0] ? mcand : '0);
`else
  assign mul_req = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
      wb_q     <= '0;
`ifdef REG_ALU_MUL_EN
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            wb_q <= '{wb_en: wb_en, wb_sel: wb_sel};
            busy <= 1'b1;
            if (mul_req) begin
              state <= MUL;
`ifdef REG_ALU_MUL_EN
              acc    <= '0;
              cnt    <= '0;
              mcand  <= {{DATA_W{1'b0}}, op_a};
              mplier <= op_b;
`endif
            end else begin
              result   <= alu_out[DATA_W-1:0];
              overflow <= alu_out[DATA_W];
              state    <= DONE;
              done     <= 1'b1;
            end
          end
        end
`ifdef REG_ALU_MUL_EN
        MUL: begin
          // Last step loads the product on the same edge, so done lands DATA_W+1 after start.
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == SH_W'(DATA_W - 1)) begin
            result   <= acc_nxt[DATA_W-1:0];
            overflow <= |acc_nxt[2*DATA_W-1:DATA_W];
            state    <= DONE;
            done     <= 1'b1;
          end
        end
`endif
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Writeback is assigned last so it overrides a host write to the same register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rf <= '0;
    end else begin
      if (wr_en)
        rf[wr_sel] <= wr_data;
      if (state == DONE && wb_q.wb_en)
        rf[wb_q.wb_sel] <= result;
    end
  end

endmodule

// File: tb/tb_reg_alu_unit.sv
// Self-checking bench for reg_alu_unit: directed scenarios plus randomized ops vs. an arithmetic model.
module tb_reg_alu_unit;
  localparam int DW = 16;
  localparam int RC = 4;
  localparam int IW = 8;
`ifdef REG_ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset_n;
  logic [DW-1:0] memval, pc, sp;
  logic [IW-1:0] immediate;
  logic          wr_en, start, src_a, wb_en;
  logic [1:0]    wr_sel, wr_src, rd_a_sel, rd_b_sel, src_b, wb_sel;
  logic [3:0]    alu_op;
  logic [DW-1:0] rd_a_data, rd_b_data, result;
  logic          busy, done, overflow;

  always #5 clock = ~clock;

  reg_alu_unit #(.DATA_W(DW), .REG_CNT(RC), .IMM_W(IW)) dut (
    .clock(clock), .reset_n(reset_n), .memval(memval), .pc(pc), .sp(sp),
    .immediate(immediate), .wr_en(wr_en), .wr_sel(wr_sel), .wr_src(wr_src),
    .rd_a_sel(rd_a_sel), .rd_b_sel(rd_b_sel), .rd_a_data(rd_a_data), .rd_b_data(rd_b_data),
    .start(start), .alu_op(alu_op), .src_a(src_a), .src_b(src_b), .wb_en(wb_en),
    .wb_sel(wb_sel), .busy(busy), .done(done), .result(result), .overflow(overflow)
  );

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] mreg [RC];
  logic [DW-1:0] m_result;

  function automatic logic [DW-1:0] sext(input logic [IW-1:0] i);
    return DW'(int'($signed(i)));
  endfunction

  // Reference: plain integer arithmetic, {overflow, result}.
  function automatic logic [DW:0] ref_alu(input int op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    int sa, sb, s;
    longint unsigned p;
    logic [DW-1:0] r;
    logic v;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r = '0;
    v = 1'b0;
    case (op)
      0: begin s = sa + sb; r = DW'(s); v = (s > 2**(DW-1) - 1) || (s < -(2**(DW-1))); end
      1: begin s = sa - sb; r = DW'(s); v = (s > 2**(DW-1) - 1) || (s < -(2**(DW-1))); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = a << (int'(b) % DW);
      6: r = a >> (int'(b) % DW);
      7: r = (sa < sb) ? DW'(1) : DW'(0);
      8: if (MUL_EN) begin
           p = 64'(a) * 64'(b);
           r = DW'(p);
           v = (p >> DW) != 0;
         end
      default: ;
    endcase
    return {v, r};
  endfunction

  function automatic logic [DW:0] exp_op(input int op, input logic sa, input logic [1:0] sb,
                                         input logic [1:0] as, input logic [1:0] bs,
                                         input logic [IW-1:0] imm, input logic [DW-1:0] spv);
    logic [DW-1:0] a, b;
    a = sa ? spv : mreg[as];
    case (sb)
      2'd0:    b = mreg[bs];
      2'd1:    b = DW'(imm);
      2'd2:    b = sext(imm);
      default: b = DW'(int'(sext(imm)) * 4);
    endcase
    return ref_alu(op, a, b);
  endfunction

  function automatic int exp_lat(input int op);
    return (MUL_EN && op == 8) ? DW + 1 : 1;
  endfunction

  task automatic host_write(input logic [1:0] sel, input logic [1:0] src, input logic [DW-1:0] memv,
                            input logic [DW-1:0] pcv, input logic [IW-1:0] imm);
    wr_en = 1'b1; wr_sel = sel; wr_src = src; memval = memv; pc = pcv; immediate = imm;
    case (src)
      2'd0:    mreg[sel] = memv;
      2'd1:    mreg[sel] = m_result;
      2'd2:    mreg[sel] = sext(imm);
      default: mreg[sel] = pcv;
    endcase
    @(negedge clock);
    wr_en = 1'b0;
  endtask

  task automatic read_reg(input logic [1:0] sel, output logic [DW-1:0] va, output logic [DW-1:0] vb);
    rd_a_sel = sel; rd_b_sel = sel;
    #1;
    va = rd_a_data; vb = rd_b_data;
  endtask

  // Drives one start and waits (bounded) for done; lat counts edges from start to the done cycle.
  task automatic do_op(input int op, input logic sa, input logic [1:0] sb, input logic [1:0] as,
                       input logic [1:0] bs, input logic [IW-1:0] imm, input logic [DW-1:0] spv,
                       input logic wb, input logic [1:0] ws, output int lat, output logic dn_after);
    alu_op = 4'(op); src_a = sa; src_b = sb; rd_a_sel = as; rd_b_sel = bs;
    immediate = imm; sp = spv; wb_en = wb; wb_sel = ws; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin
      @(negedge clock);
      lat++;
    end
    @(negedge clock);
    dn_after = done;
  endtask

  task automatic test_reset;
    logic [DW-1:0] va, vb;
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_tests++; if (result !== '0) begin n_fail++; $display("FAIL reset_result: got %h want 0", result); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    reset_n = 1'b1;
    @(negedge clock);
    for (int i = 0; i < RC; i++) begin
      mreg[i] = '0;
      read_reg(2'(i), va, vb);
      n_tests++; if (va !== '0) begin n_fail++; $display("FAIL reset_reg%0d: got %h want 0", i, va); end
    end
    m_result = '0;
  endtask

  task automatic test_add_ovf;
    int lat; logic dn; logic [DW-1:0] va, vb;
    host_write(2'd0, 2'd0, 16'h7FFF, '0, '0);
    host_write(2'd1, 2'd0, 16'h0001, '0, '0);
    do_op(0, 1'b0, 2'd0, 2'd0, 2'd1, '0, '0, 1'b1, 2'd2, lat, dn);
    n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL add_lat: got %0d want 1", lat); end
    n_tests++; if (result !== 16'h8000) begin n_fail++; $display("FAIL add_result: got %h want 8000", result); end
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL add_ovf: got %b want 1", overflow); end
    n_tests++; if (dn !== 1'b0) begin n_fail++; $display("FAIL add_done_width: got %b want 0", dn); end
    mreg[2] = 16'h8000; m_result = 16'h8000;
    read_reg(2'd2, va, vb);
    n_tests++; if (va !== 16'h8000) begin n_fail++; $display("FAIL add_wb_a: got %h want 8000", va); end
    n_tests++; if (vb !== 16'h8000) begin n_fail++; $display("FAIL add_wb_b: got %h want 8000", vb); end
  endtask

  task automatic test_imm;
    int lat; logic dn;
    do_op(0, 1'b1, 2'd3, 2'd0, 2'd0, 8'hFE, 16'h0100, 1'b0, 2'd0, lat, dn);
    n_tests++; if (result !== 16'h00F8) begin n_fail++; $display("FAIL imm_result: got %h want 00f8", result); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL imm_ovf: got %b want 0", overflow); end
    m_result = 16'h00F8;
  endtask

  task automatic test_mul;
    int lat; logic dn; logic [DW:0] e;
    host_write(2'd0, 2'd0, 16'h0100, '0, '0);
    host_write(2'd1, 2'd0, 16'h0100, '0, '0);
    e = exp_op(8, 1'b0, 2'd0, 2'd0, 2'd1, '0, '0);
    do_op(8, 1'b0, 2'd0, 2'd0, 2'd1, '0, '0, 1'b0, 2'd0, lat, dn);
    n_tests++; if (lat !== exp_lat(8)) begin n_fail++; $display("FAIL mul_lat: got %0d want %0d", lat, exp_lat(8)); end
    n_tests++; if ({overflow, result} !== e) begin n_fail++; $display("FAIL mul_big: got %b/%h want %b/%h", overflow, result, e[DW], e[DW-1:0]); end
    m_result = e[DW-1:0];
    host_write(2'd0, 2'd0, 16'd3, '0, '0);
    e = exp_op(8, 1'b0, 2'd1, 2'd0, 2'd0, 8'd5, '0);
    do_op(8, 1'b0, 2'd1, 2'd0, 2'd0, 8'd5, '0, 1'b1, 2'd3, lat, dn);
    n_tests++; if ({overflow, result} !== e) begin n_fail++; $display("FAIL mul_small: got %b/%h want %b/%h", overflow, result, e[DW], e[DW-1:0]); end
    m_result = e[DW-1:0]; mreg[3] = m_result;
  endtask

  task automatic test_reserved;
    int lat; logic dn;
    do_op(0, 1'b1, 2'd1, 2'd0, 2'd0, 8'h01, 16'h7FFF, 1'b0, 2'd0, lat, dn);
    do_op(12, 1'b1, 2'd1, 2'd0, 2'd0, 8'h01, 16'h7FFF, 1'b0, 2'd0, lat, dn);
    n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL rsv_lat: got %0d want 1", lat); end
    n_tests++; if (result !== '0) begin n_fail++; $display("FAIL rsv_result: got %h want 0", result); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rsv_ovf: got %b want 0", overflow); end
    m_result = '0;
  endtask

  task automatic test_start_ignored;
    int ndone; int op; logic [DW:0] e;
    host_write(2'd0, 2'd0, 16'd7, '0, '0);
    op = MUL_EN ? 8 : 0;
    e = exp_op(op, 1'b0, 2'd1, 2'd0, 2'd0, 8'd3, '0);
    alu_op = 4'(op); src_a = 1'b0; src_b = 2'd1; rd_a_sel = 2'd0; immediate = 8'd3;
    wb_en = 1'b0; start = 1'b1;
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (i == 1) start = 1'b0;
      if (MUL_EN && i == 5) begin alu_op = 4'd0; start = 1'b1; end
      if (MUL_EN && i == 6) start = 1'b0;
      if (done) ndone++;
    end
    n_tests++; if (ndone !== 1) begin n_fail++; $display("FAIL busy_start_pulses: got %0d want 1", ndone); end
    n_tests++; if ({overflow, result} !== e) begin n_fail++; $display("FAIL busy_start_result: got %h want %h", result, e[DW-1:0]); end
    m_result = e[DW-1:0];
  endtask

  task automatic test_collision;
    logic [DW-1:0] va, vb;
    alu_op = 4'd0; src_a = 1'b1; sp = 16'h1111; src_b = 2'd1; immediate = 8'h22;
    wb_en = 1'b1; wb_sel = 2'd3; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL coll_done: got %b want 1", done); end
    host_write(2'd3, 2'd0, 16'hDEAD, '0, '0);
    mreg[3] = 16'h1133; m_result = 16'h1133;
    read_reg(2'd3, va, vb);
    n_tests++; if (va !== 16'h1133) begin n_fail++; $display("FAIL coll_same: got %h want 1133", va); end
    immediate = 8'h44; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    host_write(2'd1, 2'd0, 16'hBEEF, '0, 8'h44);
    mreg[3] = 16'h1155; m_result = 16'h1155;
    read_reg(2'd1, va, vb);
    n_tests++; if (va !== 16'hBEEF) begin n_fail++; $display("FAIL coll_diff_host: got %h want beef", va); end
    read_reg(2'd3, va, vb);
    n_tests++; if (va !== 16'h1155) begin n_fail++; $display("FAIL coll_diff_wb: got %h want 1155", va); end
  endtask

  task automatic test_random;
    int lat, op; logic dn, sa, wb; logic [1:0] sb, as, bs, ws; logic [IW-1:0] imm;
    logic [DW-1:0] spv, va, vb; logic [DW:0] e;
    for (int i = 0; i < RC; i++) host_write(2'(i), 2'd0, DW'($urandom), '0, '0);
    for (int i = 0; i < 50; i++) begin
      if ($urandom_range(0, 3) == 0)
        host_write(2'($urandom), 2'($urandom), DW'($urandom), DW'($urandom), IW'($urandom));
      op = $urandom_range(0, 15);
      sa = 1'($urandom); sb = 2'($urandom); as = 2'($urandom); bs = 2'($urandom);
      imm = IW'($urandom); spv = DW'($urandom); wb = 1'($urandom); ws = 2'($urandom);
      e = exp_op(op, sa, sb, as, bs, imm, spv);
      do_op(op, sa, sb, as, bs, imm, spv, wb, ws, lat, dn);
      n_tests++; if (lat !== exp_lat(op)) begin n_fail++; $display("FAIL rand_lat[%0d] op%0d: got %0d want %0d", i, op, lat, exp_lat(op)); end
      n_tests++; if ({overflow, result} !== e) begin n_fail++; $display("FAIL rand_alu[%0d] op%0d: got %b/%h want %b/%h", i, op, overflow, result, e[DW], e[DW-1:0]); end
      m_result = e[DW-1:0];
      if (wb) mreg[ws] = m_result;
    end
    for (int i = 0; i < RC; i++) begin
      read_reg(2'(i), va, vb);
      n_tests++; if (va !== mreg[i]) begin n_fail++; $display("FAIL rand_reg%0d: got %h want %h", i, va, mreg[i]); end
    end
  endtask

  task automatic test_reset_mid;
    int ndone; logic [DW-1:0] va, vb;
    host_write(2'd0, 2'd0, 16'h0009, '0, '0);
    alu_op = MUL_EN ? 4'd8 : 4'd0; src_a = 1'b0; rd_a_sel = 2'd0; src_b = 2'd1;
    immediate = 8'd9; wb_en = 1'b1; wb_sel = 2'd2; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    reset_n = 1'b0;
    #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL rmid_done: got %b want 0", done); end
    @(negedge clock);
    reset_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < DW + 5; i++) begin
      @(negedge clock);
      if (done) ndone++;
    end
    n_tests++; if (ndone !== 0) begin n_fail++; $display("FAIL rmid_late_done: got %0d want 0", ndone); end
    for (int i = 0; i < RC; i++) begin
      read_reg(2'(i), va, vb);
      n_tests++; if (va !== '0) begin n_fail++; $display("FAIL rmid_reg%0d: got %h want 0", i, va); end
    end
  endtask

  initial begin
    reset_n = 1'b0; memval = '0; pc = '0; sp = '0; immediate = '0;
    wr_en = 1'b0; wr_sel = '0; wr_src = '0; rd_a_sel = '0; rd_b_sel = '0;
    start = 1'b0; alu_op = '0; src_a = 1'b0; src_b = '0; wb_en = 1'b0; wb_sel = '0;
    m_result = '0;
    test_reset();
    test_add_ovf();
    test_imm();
    test_mul();
    test_reserved();
    test_start_ignored();
    test_collision();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
